// File: rtl/uart_word_tx_if.sv
// Word handshake and serial line bundle for uart_word_tx.
// Master offers words; slave serialises them onto txd.
interface uart_word_tx_if #(
  parameter int NUM_BYTES = 2
) ();

  logic [8*NUM_BYTES-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   txd;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  txd
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output txd
  );

endinterface

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter, optional parity, 1/2 stop bits.
// Fractional baud accumulator; txd and status are all registered.
module uart_word_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int ACC_WIDTH = 16,
  parameter int NUM_BYTES = 2,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_word_tx_if.slave bus
);

  localparam longint unsigned INC_L =
    ((longint'(BAUD) << (ACC_WIDTH - 4))
     + longint'(CLK_FREQ >> 5))
    / longint'(CLK_FREQ >> 4);

  localparam logic [ACC_WIDTH-1:0] INC =
    ACC_WIDTH'(INC_L);

  localparam int BIW =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BIW-1:0] LAST_BYTE =
    BIW'(NUM_BYTES - 1);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 r_state;
  logic                   r_txd;
  logic                   r_ready;
  logic                   r_done;
  logic [8*NUM_BYTES-1:0] r_word;
  logic [BIW-1:0]         r_byte_idx;
  logic [2:0]             r_bit_idx;
  logic                   r_stop_cnt;
  logic [ACC_WIDTH:0]     r_acc;

  logic                   w_accept;
  logic                   w_tick;
  logic [7:0]             w_byte;
  logic                   w_par;
  logic                   w_next_bit;

  assign w_accept = bus.tx_valid & r_ready;
  assign w_tick   = r_acc[ACC_WIDTH];

  // Select the byte currently on the line.
  always_comb begin
    w_byte = r_word[7:0];
    for (int i = 1; i < NUM_BYTES; i++) begin
      if (r_byte_idx == BIW'(i)) begin
        w_byte = r_word[8*i +: 8];
      end
    end
  end

  assign w_par = (PARITY == 2) ? (^w_byte)
                               : (~^w_byte);

  assign w_next_bit = w_byte[r_bit_idx + 3'd1];

  // Baud accumulator; zero while idle, the accept edge
  // counts as the first clock of the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == IDLE) begin
      r_acc <= w_accept ? {1'b0, INC} : '0;
    end else begin
      r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]}
             + {1'b0, INC};
    end
  end

  // Frame sequencer with registered line and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_word     <= bus.tx_data;
            r_byte_idx <= '0;
            r_state    <= START;
            r_txd      <= 1'b0;
            r_ready    <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_txd     <= w_byte[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                r_state <= PAR;
                r_txd   <= w_par;
              end else begin
                r_state    <= STOP;
                r_txd      <= 1'b1;
                r_stop_cnt <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_next_bit;
            end
          end
        end
        PAR: begin
          if (w_tick) begin
            r_state    <= STOP;
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == STOP_LAST) begin
              if (r_byte_idx != LAST_BYTE) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                r_state    <= START;
                r_txd      <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_ready <= 1'b1;
                r_done  <= 1'b1;
                r_txd   <= 1'b1;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_ready = r_ready;
  assign bus.tx_busy  = ~r_ready;
  assign bus.tx_done  = r_done;
  assign bus.txd      = r_txd;

endmodule
